// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the controller state encoding, the default depth and the reset level.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        ISSUE = 2'd2
    } hz_state_e;

    localparam int   DEF_STAGES = 5;
    localparam logic RST_ACTIVE = 1'b0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
// Latency: count visible one cycle after i_inc; no backpressure, holds at MAX.
module sat_counter
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int           W   = 32,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != MAX)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush arbiter with deferred-flush register and deadlock watchdog.
// Zero-latency stall/flush decode; blocked flushes wait in a pending slot until unblocked.
// Optional HAZARD_PERF_EN adds saturating stall-cycle and flush-issue counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int STAGES     = DEF_STAGES,
    parameter int WDOG_LIMIT = 1024,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt_i,
    input  logic [STAGES-1:0] stall_req_i,
    input  logic [STAGES-1:0] flush_req_i,
    input  logic              wdog_clr_i,
    output logic [STAGES-1:0] stall_o,
    output logic [STAGES-1:0] flush_o,
    output logic              pend_o,
    output logic              wdog_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles_o,
    output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

    localparam int                IW       = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [STAGES-1:0] NO_FETCH = {{(STAGES-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0]  WD_LIM   = CNT_W'(WDOG_LIMIT);

    logic [STAGES-1:0] w_base, w_blk, w_fl_req, w_unblk, w_blk_req;
    logic              w_pend_vld, w_pend_go, w_issue, w_nb_vld, w_pn_vld, w_rst_off;
    logic [IW-1:0]     w_f, w_nb_idx, w_pn_idx, r_pend_idx;
    hz_state_e         r_state, w_state;

    // w_blk[j]: halt or a stall somewhere strictly older than stage j.
    always_comb begin : thermo
        logic w_acc;
        w_acc  = halt_i;
        w_base = '0;
        w_blk  = '0;
        for (int j = STAGES - 1; j >= 0; j--) begin
            w_blk[j]  = w_acc;
            w_acc     = w_acc | stall_req_i[j];
            w_base[j] = w_acc;
        end
    end

    assign w_fl_req   = flush_req_i & NO_FETCH;
    assign w_unblk    = w_fl_req & ~w_blk;
    assign w_blk_req  = w_fl_req & w_blk;
    assign w_pend_vld = (r_state != RUN);
    assign w_pend_go  = w_pend_vld && !w_blk[r_pend_idx];

    always_comb begin : arb
        w_issue  = 1'b0;
        w_f      = '0;
        w_nb_vld = 1'b0;
        w_nb_idx = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (w_unblk[k] || (w_pend_go && (r_pend_idx == IW'(k)))) begin
                w_issue = 1'b1;
                w_f     = IW'(k);
            end
            if (w_blk_req[k]) begin
                w_nb_vld = 1'b1;
                w_nb_idx = IW'(k);
            end
        end
    end

    // Requests younger than the winning flush sit in flushed stages and are wrong-path.
    always_comb begin : nxt
        w_pn_vld = 1'b0;
        w_pn_idx = r_pend_idx;
        if (w_issue) begin
            if (w_nb_vld && (w_nb_idx > w_f)) begin
                w_pn_vld = 1'b1;
                w_pn_idx = w_nb_idx;
            end
        end else if (w_nb_vld && (!w_pend_vld || (w_nb_idx > r_pend_idx))) begin
            w_pn_vld = 1'b1;
            w_pn_idx = w_nb_idx;
        end else begin
            w_pn_vld = w_pend_vld;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            r_state    <= RUN;
            r_pend_idx <= '0;
        end else begin
            r_state    <= w_pn_vld ? HOLD : RUN;
            r_pend_idx <= w_pn_idx;
        end
    end

    assign w_state   = w_pend_go ? ISSUE : r_state;
    assign pend_o    = (w_state != RUN);
    assign w_rst_off = (rst != RST_ACTIVE);

    always_comb begin : drive
        flush_o = '0;
        stall_o = '0;
        for (int j = 0; j < STAGES; j++) begin
            flush_o[j] = w_rst_off && w_issue && (IW'(j) < w_f);
            stall_o[j] = w_rst_off && w_base[j] && !flush_o[j];
        end
    end

    logic [CNT_W-1:0] w_wd_cnt;
    logic             w_wd_inc, r_wdog;

    assign w_wd_inc = w_base[0] && !halt_i;

    sat_counter #(.W(CNT_W), .MAX(WD_LIM)) u_wdog_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (wdog_clr_i || !w_base[0]),
        .i_inc (w_wd_inc),
        .o_cnt (w_wd_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            r_wdog <= 1'b0;
        end else if (wdog_clr_i) begin
            r_wdog <= 1'b0;
        end else if (w_wd_inc && (w_wd_cnt == WD_LIM - CNT_W'(1))) begin
            r_wdog <= 1'b1;
        end
    end

    assign wdog_o = r_wdog;

`ifdef HAZARD_PERF_EN
    sat_counter #(.W(CNT_W), .MAX({CNT_W{1'b1}})) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (1'b0),
        .i_inc (|stall_o),
        .o_cnt (stall_cycles_o)
    );

    sat_counter #(.W(CNT_W), .MAX({CNT_W{1'b1}})) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (1'b0),
        .i_inc (w_issue),
        .o_cnt (flush_cnt_o)
    );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised and directed bench for pipe_hazard_ctrl against an index-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int S   = 5;
    localparam int LIM = 8;
    localparam int CW  = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         halt_i = 1'b0;
    logic         wdog_clr_i = 1'b0;
    logic [S-1:0] stall_req_i = '0;
    logic [S-1:0] flush_req_i = '0;
    logic [S-1:0] stall_o, flush_o;
    logic         pend_o, wdog_o;
`ifdef HAZARD_PERF_EN
    logic [CW-1:0] stall_cycles_o, flush_cnt_o;
`endif

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.STAGES(S), .WDOG_LIMIT(LIM), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .halt_i      (halt_i),
        .stall_req_i (stall_req_i),
        .flush_req_i (flush_req_i),
        .wdog_clr_i  (wdog_clr_i),
        .stall_o     (stall_o),
        .flush_o     (flush_o),
        .pend_o      (pend_o),
        .wdog_o      (wdog_o)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles_o (stall_cycles_o),
        .flush_cnt_o    (flush_cnt_o)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: pending stage index (-1 none), watchdog count and flag.
    int m_pend = -1;
    int m_wcnt = 0;
    bit m_wdog = 1'b0;
    int m_scyc = 0;
    int m_fcnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = -1;
        m_wcnt = 0;
        m_wdog = 1'b0;
        m_scyc = 0;
        m_fcnt = 0;
    endtask

    task automatic step(input bit h, input logic [S-1:0] st, input logic [S-1:0] fl, input bit clr,
                        output logic [S-1:0] o_st, output logic [S-1:0] o_fl, output logic o_pd,
                        output logic o_wd);
        int hi, f, hb, pn, wn;
        logic [S-1:0] e_st, e_fl;
        @(negedge clk);
        halt_i      = h;
        stall_req_i = st;
        flush_req_i = fl;
        wdog_clr_i  = clr;
        #1;
        // hi: oldest stalled stage (S when halted); a stage k is blocked iff k < hi.
        hi = -1;
        for (int k = 0; k < S; k++) if (st[k]) hi = k;
        if (h) hi = S;
        f  = (m_pend >= 0 && m_pend >= hi) ? m_pend : -1;
        hb = -1;
        for (int k = 1; k < S; k++) begin
            if (fl[k]) begin
                if (k >= hi) begin
                    if (k > f) f = k;
                end else begin
                    hb = k;
                end
            end
        end
        for (int j = 0; j < S; j++) begin
            e_fl[j] = (j < f);
            e_st[j] = (j <= hi) && (j >= f);
        end
        o_st = stall_o;
        o_fl = flush_o;
        o_pd = pend_o;
        o_wd = wdog_o;
        check("stall_o", 32'(stall_o), 32'(e_st));
        check("flush_o", 32'(flush_o), 32'(e_fl));
        check("pend_o", 32'(pend_o), 32'(m_pend >= 0));
        check("wdog_o", 32'(wdog_o), 32'(m_wdog));
`ifdef HAZARD_PERF_EN
        check("stall_cycles_o", stall_cycles_o, 32'(m_scyc));
        check("flush_cnt_o", flush_cnt_o, 32'(m_fcnt));
`endif
        if (f >= 0) pn = (hb > f) ? hb : -1;
        else        pn = (hb > m_pend) ? hb : m_pend;
        if (clr || hi < 0) wn = 0;
        else if (!h)       wn = (m_wcnt < LIM) ? m_wcnt + 1 : LIM;
        else               wn = m_wcnt;
        @(posedge clk);
        m_pend = pn;
        m_wcnt = wn;
        m_wdog = !clr && (m_wdog || (wn == LIM));
        m_scyc = m_scyc + int'(e_st != '0);
        m_fcnt = m_fcnt + int'(f >= 0);
    endtask

    task automatic do_reset(input bit h, input logic [S-1:0] st, input logic [S-1:0] fl);
        @(negedge clk);
        halt_i      = h;
        stall_req_i = st;
        flush_req_i = fl;
        wdog_clr_i  = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_flush", 32'(flush_o), 32'd0);
        check("rst_pend", 32'(pend_o), 32'd0);
        check("rst_wdog", 32'(wdog_o), 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_stall", 32'(stall_o), 32'd0);
        check("rst_hold_pend", 32'(pend_o), 32'd0);
        @(negedge clk);
        halt_i      = 1'b0;
        stall_req_i = '0;
        flush_req_i = '0;
        rst         = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [S-1:0] s, f;
        logic         p, w;

        do_reset(1'b1, 5'b11111, 5'b11110);

        step(0, 5'b00010, 5'b00000, 0, s, f, p, w);  check("thermo_1", 32'(s), 32'b00011);
        step(0, 5'b00100, 5'b00000, 0, s, f, p, w);  check("thermo_2", 32'(s), 32'b00111);
        step(0, 5'b10000, 5'b00000, 0, s, f, p, w);  check("thermo_4", 32'(s), 32'b11111);
        step(1, 5'b00000, 5'b00000, 0, s, f, p, w);  check("thermo_halt", 32'(s), 32'b11111);

        step(0, 5'b00000, 5'b01000, 0, s, f, p, w);
        check("flush3_fl", 32'(f), 32'b00111);
        check("flush3_st", 32'(s), 32'b00000);
        check("flush3_pd", 32'(p), 32'd0);

        step(0, 5'b10000, 5'b00100, 0, s, f, p, w);  check("defer_fl0", 32'(f), 32'd0);
        step(0, 5'b10000, 5'b00100, 0, s, f, p, w);  check("defer_pd", 32'(p), 32'd1);
        step(0, 5'b10000, 5'b00100, 0, s, f, p, w);  check("defer_fl", 32'(f), 32'd0);
        step(0, 5'b00000, 5'b00000, 0, s, f, p, w);  check("defer_issue", 32'(f), 32'b00011);
        step(0, 5'b00000, 5'b00000, 0, s, f, p, w);  check("defer_done", 32'(p), 32'd0);

        step(0, 5'b10000, 5'b00100, 0, s, f, p, w);
        step(0, 5'b10000, 5'b01000, 0, s, f, p, w);
        step(0, 5'b10000, 5'b00010, 0, s, f, p, w);  check("upgrade_pd", 32'(p), 32'd1);
        step(0, 5'b00000, 5'b00000, 0, s, f, p, w);  check("upgrade_issue", 32'(f), 32'b00111);
        step(0, 5'b00000, 5'b00000, 0, s, f, p, w);  check("upgrade_once", 32'(f), 32'd0);

        step(0, 5'b00000, 5'b00000, 1, s, f, p, w);
        for (int i = 0; i < LIM; i++) begin
            step(0, 5'b00001, 5'b00000, 0, s, f, p, w);
            check("wdog_pre", 32'(w), 32'd0);
        end
        step(0, 5'b00000, 5'b00000, 0, s, f, p, w);  check("wdog_trip", 32'(w), 32'd1);
        step(0, 5'b00000, 5'b00000, 0, s, f, p, w);  check("wdog_sticky", 32'(w), 32'd1);
        step(0, 5'b00000, 5'b00000, 1, s, f, p, w);
        step(0, 5'b00000, 5'b00000, 0, s, f, p, w);  check("wdog_clr", 32'(w), 32'd0);

        step(0, 5'b10000, 5'b00100, 0, s, f, p, w);
        step(0, 5'b10000, 5'b00100, 0, s, f, p, w);  check("rst_pre_pd", 32'(p), 32'd1);
        do_reset(1'b0, 5'b10000, 5'b00100);
        step(0, 5'b00000, 5'b00000, 0, s, f, p, w);
        check("rst_post_fl", 32'(f), 32'd0);
        check("rst_post_pd", 32'(p), 32'd0);

        for (int i = 0; i < 800; i++) begin
            logic [S-1:0] rs, rf;
            bit rh, rc;
            if ($urandom_range(0, 149) == 0) begin
                do_reset(1'($urandom), S'($urandom), S'($urandom));
            end
            rh = ($urandom_range(0, 7) == 0);
            rs = S'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 3) == 0) rs = '0;
            if ($urandom_range(0, 9) == 0) rs = 5'b00001;
            rf = S'($urandom & $urandom);
            rc = ($urandom_range(0, 15) == 0);
            step(rh, rs, rf, rc, s, f, p, w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
